sram_march_bist: RTL and testbench
==================================

SRAM_MARCH_BIST -- requirements
Module: sram_march_bist

Interface
REQ-001 SHALL have parameter NumWords, default 1024, number of SRAM words (>=2).
REQ-002 SHALL have parameter DataWidth, default 32, SRAM word width in bits.
REQ-003 SHALL have parameter ByteWidth, default 8, bits per byte-enable.
REQ-004 SHALL derive AddrWidth = $clog2(NumWords) and BeWidth = ceil(DataWidth/ByteWidth); these SHALL not be overridden.
REQ-005 SHALL have ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset, asynchronous, active-low.
- start_i  in  1  start March C- test; sampled only in IDLE.
- busy_o  out  1  test in progress.
- done_o  out  1  one-cycle pulse at test end.
- fail_o  out  1  sticky, any mismatch in last test.
- fail_addr_o  out  AddrWidth  address of first mismatch.
- func_req_i / func_we_i  in  1 / 1  functional request / write.
- func_addr_i / func_wdata_i / func_be_i  in  AddrWidth / DataWidth / BeWidth  functional request fields.
- func_gnt_o  out  1  functional request accepted.
- func_rvalid_o  out  1  response valid for granted request.
- func_rdata_o  out  DataWidth  functional read data.
- sram_req_o / sram_we_o  out  1 / 1  to single-port latency-1 SRAM.
- sram_addr_o / sram_wdata_o / sram_be_o  out  AddrWidth / DataWidth / BeWidth  SRAM request fields.
- sram_rdata_i  in  DataWidth  SRAM read data, valid the cycle after a read.

Function
REQ-006 SHALL implement states IDLE, M0, M1, M2, M3, M4, M5, CHECK, DONE.
REQ-007 IDLE with start_i=1 SHALL go to M0 at the next edge and clear fail_o and fail_addr_o.
REQ-008 In IDLE, func_gnt_o SHALL equal ~start_i, and sram_* SHALL pass func_* through combinationally, with sram_req_o = func_req_i & ~start_i.
REQ-009 func_rvalid_o SHALL be registered func_req_i & func_gnt_o, and func_rdata_o SHALL equal sram_rdata_i.
REQ-010 In all states other than IDLE, func_gnt_o SHALL be 0, and sram_* SHALL be driven only by the BIST sequencer with sram_be_o all ones.
REQ-011 Element order SHALL be:
- M0: ascending w0.
- M1: ascending (r0, w1).
- M2: ascending (r1, w0).
- M3: descending (r0, w1).
- M4: descending (r1, w0).
- M5: ascending r0.
- "0"/"1" mean all-zeros/all-ones words.
REQ-012 Each access SHALL take exactly one cycle with sram_req_o=1; a read-write pair on an address SHALL use two consecutive cycles (read, then write), giving 10*NumWords access cycles with no gaps.
REQ-013 The address counter SHALL run 0..NumWords-1 ascending and NumWords-1..0 descending, and SHALL reload the start address of the next element without wrap-around artefacts.
REQ-014 Each read's expected value and address SHALL be registered; sram_rdata_i SHALL be compared the following cycle, including the last M5 read, which is compared in CHECK.
REQ-015 On a mismatch with fail_o=0, the FSM SHALL set fail_o and capture the read address into fail_addr_o; later mismatches SHALL not change fail_addr_o.
REQ-016 The test SHALL not abort on failure.
REQ-017 busy_o SHALL be 1 in states M0..CHECK.
REQ-018 CHECK SHALL go to DONE, where done_o=1 for one cycle, then return to IDLE.
REQ-019 Timing SHALL be: start_i sampled at edge 0, accesses in cycles 1..10N, compare of the last read in cycle 10N+1, done_o in cycle 10N+2.
REQ-020 start_i SHALL be ignored outside IDLE.
REQ-021 fail_o and fail_addr_o SHALL hold until the next accepted start or reset.

Reset
REQ-022 Asserting rst_ni low at any time, including mid-test, SHALL immediately force:
- state IDLE.
- busy_o, done_o, fail_o, func_rvalid_o = 0.
- fail_addr_o = 0.
- internal counters and compare registers = 0.
REQ-023 After rst_ni deassertion, the first possible start SHALL be at the next rising edge.

Verification
REQ-024 NumWords=8, DataWidth=32, fault-free SRAM model, start_i pulse: SHALL give busy_o for cycles 1..81, done_o in cycle 82, fail_o=0, and 80 SRAM accesses in the exact order of REQ-011.
REQ-025 Same setup with bit 3 of sram_rdata_i flipped on reads of address 5: SHALL give fail_o=1 and fail_addr_o=5 at done.
REQ-026 Stuck-at-1 word at address 2 and a second at address 6: SHALL give fail_addr_o=2 from the M1 read of address 2.
REQ-027 In IDLE, func write 0xDEADBEEF to address 3, then read: func_gnt_o=1 both cycles, func_rvalid_o one cycle after each grant, rdata 0xDEADBEEF; during the test, func_req_i=1 gives func_gnt_o=0.
REQ-028 func_req_i and start_i both high in IDLE: func_gnt_o=0 and sram_req_o=0 in that cycle, and the test starts.
REQ-029 rst_ni low in cycle 40 of a test: all outputs 0 immediately; after release, a new start SHALL complete normally with done_o at cycle 82.

Source files
------------

// File: rtl/sram_march_bist.sv
// March C- built-in self test for a single-port, latency-1 SRAM.
// The functional port passes straight through to the SRAM while the sequencer is idle.
module sram_march_bist #(
    parameter int unsigned NumWords  = 1024,
    parameter int unsigned DataWidth = 32,
    parameter int unsigned ByteWidth = 8,
    localparam int unsigned AddrWidth = $clog2(NumWords),
    localparam int unsigned BeWidth   = (DataWidth + ByteWidth - 1) / ByteWidth
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 start_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 fail_o,
    output logic [AddrWidth-1:0] fail_addr_o,
    input  logic                 func_req_i,
    input  logic                 func_we_i,
    input  logic [AddrWidth-1:0] func_addr_i,
    input  logic [DataWidth-1:0] func_wdata_i,
    input  logic [BeWidth-1:0]   func_be_i,
    output logic                 func_gnt_o,
    output logic                 func_rvalid_o,
    output logic [DataWidth-1:0] func_rdata_o,
    output logic                 sram_req_o,
    output logic                 sram_we_o,
    output logic [AddrWidth-1:0] sram_addr_o,
    output logic [DataWidth-1:0] sram_wdata_o,
    output logic [BeWidth-1:0]   sram_be_o,
    input  logic [DataWidth-1:0] sram_rdata_i
);

    typedef enum logic [3:0] {
        IDLE, M0, M1, M2, M3, M4, M5, CHECK, DONE
    } state_e;

    localparam logic [AddrWidth-1:0] LastAddr = AddrWidth'(NumWords - 1);

    state_e                 state_q, state_d;
    logic [AddrWidth-1:0]   addr_q, addr_d;
    logic                   ph_q, ph_d;       // 0: read half, 1: write half of an r/w pair
    logic                   cmp_vld_q, cmp_exp_q;
    logic [AddrWidth-1:0]   cmp_addr_q;
    logic                   fail_q;
    logic [AddrWidth-1:0]   fail_addr_q;
    logic                   rvalid_q;

    logic                   bist_req, bist_we, bist_wval;
    logic                   rd_issue, rd_exp;
    logic                   desc, rval, elem_end;
    logic                   mismatch;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            addr_q  <= '0;
            ph_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            ph_q    <= ph_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        ph_d      = ph_q;
        bist_req  = 1'b0;
        bist_we   = 1'b0;
        bist_wval = 1'b0;
        rd_issue  = 1'b0;
        rd_exp    = 1'b0;
        desc      = (state_q == M3) || (state_q == M4);
        rval      = (state_q == M2) || (state_q == M4);
        elem_end  = desc ? (addr_q == '0) : (addr_q == LastAddr);
        unique case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d = M0;
                    addr_d  = '0;
                    ph_d    = 1'b0;
                end
            end
            M0: begin
                bist_req = 1'b1;
                bist_we  = 1'b1;
                if (elem_end) begin
                    state_d = M1;
                    addr_d  = '0;
                end else begin
                    addr_d = addr_q + 1'b1;
                end
            end
            M1, M2, M3, M4: begin
                bist_req = 1'b1;
                if (!ph_q) begin
                    rd_issue = 1'b1;
                    rd_exp   = rval;
                    ph_d     = 1'b1;
                end else begin
                    bist_we   = 1'b1;
                    bist_wval = ~rval;
                    ph_d      = 1'b0;
                    if (elem_end) begin
                        state_d = state_e'(state_q + 4'd1);
                        // M3 and M4 walk downwards, so they start from the top
                        addr_d  = (state_q == M2 || state_q == M3) ? LastAddr : '0;
                    end else begin
                        addr_d = desc ? addr_q - 1'b1 : addr_q + 1'b1;
                    end
                end
            end
            M5: begin
                bist_req = 1'b1;
                rd_issue = 1'b1;
                if (elem_end) begin
                    state_d = CHECK;
                    addr_d  = '0;
                end else begin
                    addr_d = addr_q + 1'b1;
                end
            end
            CHECK:   state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Functional port owns the SRAM only in IDLE, and yields to a start in the same cycle.
    always_comb begin
        func_gnt_o   = 1'b0;
        sram_req_o   = bist_req;
        sram_we_o    = bist_we;
        sram_addr_o  = addr_q;
        sram_wdata_o = {DataWidth{bist_wval}};
        sram_be_o    = '1;
        if (state_q == IDLE) begin
            func_gnt_o   = ~start_i;
            sram_req_o   = func_req_i & ~start_i;
            sram_we_o    = func_we_i;
            sram_addr_o  = func_addr_i;
            sram_wdata_o = func_wdata_i;
            sram_be_o    = func_be_i;
        end
    end

    assign mismatch = cmp_vld_q && (sram_rdata_i != {DataWidth{cmp_exp_q}});

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cmp_vld_q   <= 1'b0;
            cmp_exp_q   <= 1'b0;
            cmp_addr_q  <= '0;
            fail_q      <= 1'b0;
            fail_addr_q <= '0;
            rvalid_q    <= 1'b0;
        end else begin
            cmp_vld_q  <= rd_issue;
            cmp_exp_q  <= rd_exp;
            cmp_addr_q <= addr_q;
            rvalid_q   <= func_req_i & func_gnt_o;
            if (state_q == IDLE && start_i) begin
                fail_q      <= 1'b0;
                fail_addr_q <= '0;
            end else if (mismatch && !fail_q) begin
                fail_q      <= 1'b1;
                fail_addr_q <= cmp_addr_q;
            end
        end
    end

    assign busy_o        = (state_q != IDLE) && (state_q != DONE);
    assign done_o        = (state_q == DONE);
    assign fail_o        = fail_q;
    assign fail_addr_o   = fail_addr_q;
    assign func_rvalid_o = rvalid_q;
    assign func_rdata_o  = sram_rdata_i;

endmodule

// File: tb/tb_sram_march_bist.sv
// Directed bench for sram_march_bist with an 8-word SRAM model and injectable read faults.
module tb_sram_march_bist;

    localparam int N = 8;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        start_i;
    logic        busy_o, done_o, fail_o;
    logic [2:0]  fail_addr_o;
    logic        func_req_i, func_we_i;
    logic [2:0]  func_addr_i;
    logic [31:0] func_wdata_i;
    logic [3:0]  func_be_i;
    logic        func_gnt_o, func_rvalid_o;
    logic [31:0] func_rdata_o;
    logic        sram_req_o, sram_we_o;
    logic [2:0]  sram_addr_o;
    logic [31:0] sram_wdata_o;
    logic [3:0]  sram_be_o;
    logic [31:0] sram_rdata_i;

    int checks = 0;
    int errors = 0;
    int fault  = 0;   // 0 none, 1 bit3 flip on addr 5, 2 stuck-at-1 words at 2 and 6

    logic [31:0] mem [N];

    always #5 clk_i = ~clk_i;

    sram_march_bist #(.NumWords(N), .DataWidth(32), .ByteWidth(8)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i),
        .busy_o(busy_o), .done_o(done_o), .fail_o(fail_o), .fail_addr_o(fail_addr_o),
        .func_req_i(func_req_i), .func_we_i(func_we_i), .func_addr_i(func_addr_i),
        .func_wdata_i(func_wdata_i), .func_be_i(func_be_i),
        .func_gnt_o(func_gnt_o), .func_rvalid_o(func_rvalid_o), .func_rdata_o(func_rdata_o),
        .sram_req_o(sram_req_o), .sram_we_o(sram_we_o), .sram_addr_o(sram_addr_o),
        .sram_wdata_o(sram_wdata_o), .sram_be_o(sram_be_o), .sram_rdata_i(sram_rdata_i)
    );

    // Latency-1 SRAM with byte enables and fault injection on the read path.
    always @(posedge clk_i) begin
        if (sram_req_o) begin
            if (sram_we_o) begin
                for (int b = 0; b < 4; b++)
                    if (sram_be_o[b]) mem[sram_addr_o][8*b +: 8] <= sram_wdata_o[8*b +: 8];
            end else begin
                if (fault == 1 && sram_addr_o == 3'd5)
                    sram_rdata_i <= mem[sram_addr_o] ^ 32'h8;
                else if (fault == 2 && (sram_addr_o == 3'd2 || sram_addr_o == 3'd6))
                    sram_rdata_i <= 32'hFFFF_FFFF;
                else
                    sram_rdata_i <= mem[sram_addr_o];
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // March C- access k (0..79) for N=8, derived from the element list.
    function automatic void exp_access(input int k, output logic we, output logic [2:0] a,
                                       output logic [31:0] wd);
        int j, e, i;
        logic v;
        wd = 32'h0;
        if (k < 8) begin
            we = 1'b1; a = 3'(k);
        end else if (k < 72) begin
            j  = k - 8;
            e  = j / 16;
            i  = (j % 16) / 2;
            v  = (e == 1 || e == 3);
            a  = (e >= 2) ? 3'(7 - i) : 3'(i);
            we = (j % 2) == 1;
            wd = v ? 32'h0 : 32'hFFFF_FFFF;
        end else begin
            we = 1'b0; a = 3'(k - 72);
        end
    endfunction

    task automatic run_test(input int flt, input bit with_func, input int abort_at,
                            input bit exp_fail, input logic [2:0] exp_addr);
        logic        we;
        logic [2:0]  a;
        logic [31:0] wd;
        fault = flt;
        @(negedge clk_i);
        start_i = 1'b1;
        if (with_func) begin
            func_req_i = 1'b1;
            func_we_i  = 1'b0;
            #1;
            chk("start_gnt", 32'(func_gnt_o), 32'(0));
            chk("start_sram_req", 32'(sram_req_o), 32'(0));
        end
        @(posedge clk_i);
        #1 start_i = 1'b0;
        for (int c = 1; c <= 82; c++) begin
            @(negedge clk_i);
            if (c == abort_at) begin
                rst_ni = 1'b0;
                #1;
                chk("abort_busy", 32'(busy_o), 32'(0));
                chk("abort_done", 32'(done_o), 32'(0));
                chk("abort_fail", 32'(fail_o), 32'(0));
                chk("abort_fail_addr", 32'(fail_addr_o), 32'(0));
                chk("abort_rvalid", 32'(func_rvalid_o), 32'(0));
                chk("abort_sram_req", 32'(sram_req_o), 32'(0));
                @(negedge clk_i);
                rst_ni = 1'b1;
                return;
            end
            chk($sformatf("busy_c%0d", c), 32'(busy_o), 32'(c <= 81));
            chk($sformatf("done_c%0d", c), 32'(done_o), 32'(c == 82));
            if (c == 1) chk("fail_cleared", 32'(fail_o), 32'(0));
            if (with_func && c <= 81) chk($sformatf("gnt_c%0d", c), 32'(func_gnt_o), 32'(0));
            if (c <= 80) begin
                exp_access(c - 1, we, a, wd);
                chk($sformatf("req_c%0d", c), 32'(sram_req_o), 32'(1));
                chk($sformatf("we_c%0d", c), 32'(sram_we_o), 32'(we));
                chk($sformatf("addr_c%0d", c), 32'(sram_addr_o), 32'(a));
                chk($sformatf("be_c%0d", c), 32'(sram_be_o), 32'hF);
                if (we) chk($sformatf("wdata_c%0d", c), sram_wdata_o, wd);
            end else begin
                chk($sformatf("req_c%0d", c), 32'(sram_req_o), 32'(0));
            end
            // a start pulse mid-test must be ignored
            if (with_func && c == 40) start_i = 1'b1;
            if (with_func && c == 41) start_i = 1'b0;
            if (c == 82) begin
                chk("fail_at_done", 32'(fail_o), 32'(exp_fail));
                chk("fail_addr_at_done", 32'(fail_addr_o), 32'(exp_addr));
                func_req_i = 1'b0;
            end
        end
        @(negedge clk_i);
        chk("done_one_cycle", 32'(done_o), 32'(0));
        chk("idle_not_busy", 32'(busy_o), 32'(0));
    endtask

    initial begin
        for (int i = 0; i < N; i++) mem[i] = 32'h0;
        sram_rdata_i = 32'h0;
        rst_ni       = 1'b0;
        start_i      = 1'b0;
        func_req_i   = 1'b0;
        func_we_i    = 1'b0;
        func_addr_i  = 3'd0;
        func_wdata_i = 32'h0;
        func_be_i    = 4'h0;
        repeat (2) @(negedge clk_i);
        chk("rst_busy", 32'(busy_o), 32'(0));
        chk("rst_done", 32'(done_o), 32'(0));
        chk("rst_fail", 32'(fail_o), 32'(0));
        chk("rst_fail_addr", 32'(fail_addr_o), 32'(0));
        chk("rst_rvalid", 32'(func_rvalid_o), 32'(0));
        rst_ni = 1'b1;

        // functional write then read through the idle pass-through
        @(negedge clk_i);
        func_req_i = 1'b1; func_we_i = 1'b1; func_addr_i = 3'd3;
        func_wdata_i = 32'hDEAD_BEEF; func_be_i = 4'hF;
        #1;
        chk("fw_gnt", 32'(func_gnt_o), 32'(1));
        chk("fw_sram_req", 32'(sram_req_o), 32'(1));
        chk("fw_sram_we", 32'(sram_we_o), 32'(1));
        chk("fw_sram_addr", 32'(sram_addr_o), 32'(3));
        chk("fw_sram_wdata", sram_wdata_o, 32'hDEAD_BEEF);
        @(negedge clk_i);
        chk("fw_rvalid", 32'(func_rvalid_o), 32'(1));
        func_we_i = 1'b0;
        #1;
        chk("fr_gnt", 32'(func_gnt_o), 32'(1));
        chk("fr_sram_we", 32'(sram_we_o), 32'(0));
        @(negedge clk_i);
        func_req_i = 1'b0;
        #1;
        chk("fr_rvalid", 32'(func_rvalid_o), 32'(1));
        chk("fr_rdata", func_rdata_o, 32'hDEAD_BEEF);
        @(negedge clk_i);
        chk("rvalid_drop", 32'(func_rvalid_o), 32'(0));

        run_test(0, 1'b1, 0, 1'b0, 3'd0);
        run_test(1, 1'b0, 0, 1'b1, 3'd5);
        repeat (3) @(negedge clk_i);
        chk("fail_hold", 32'(fail_o), 32'(1));
        chk("fail_addr_hold", 32'(fail_addr_o), 32'(5));
        run_test(2, 1'b0, 0, 1'b1, 3'd2);
        run_test(0, 1'b0, 40, 1'b0, 3'd0);
        run_test(0, 1'b0, 0, 1'b0, 3'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
